// File: rtl/adder_tree_term_packer_if.sv
// Bundle of the serial term stream, the packed vector bus and the framing error
// flag around adder_tree_term_packer. The packer takes the slave view.
interface adder_tree_term_packer_if #(
   parameter int NUM_ELEMENTS = 4,
   parameter int BIT_LEN      = 16,
   parameter int CTL_BITS     = 8,
   parameter int CNT_BITS     = $clog2(NUM_ELEMENTS + 1)
) ();
   logic [BIT_LEN-1:0]                   i_dat;
   logic                                 i_val;
   logic                                 i_sop;
   logic                                 i_eop;
   logic [CTL_BITS-1:0]                  i_ctl;
   logic                                 o_rdy;
   logic [NUM_ELEMENTS-1:0][BIT_LEN-1:0] o_terms;
   logic [CNT_BITS-1:0]                  o_cnt;
   logic                                 o_val;
   logic                                 o_sop;
   logic                                 o_eop;
   logic [CTL_BITS-1:0]                  o_ctl;
   logic                                 i_rdy;
   logic                                 o_err;

   modport slave (
      input  i_dat, i_val, i_sop, i_eop, i_ctl, i_rdy,
      output o_rdy, o_terms, o_cnt, o_val, o_sop, o_eop, o_ctl, o_err
   );

   modport master (
      output i_dat, i_val, i_sop, i_eop, i_ctl, i_rdy,
      input  o_rdy, o_terms, o_cnt, o_val, o_sop, o_eop, o_ctl, o_err
   );
endinterface

// File: rtl/adder_tree_term_packer.sv
// Packs a sop/eop framed stream of single terms into NUM_ELEMENTS-wide,
// zero-padded vectors for the adder tree, one vector per handshake.
module adder_tree_term_packer #(
   parameter int NUM_ELEMENTS = 4,
   parameter int BIT_LEN      = 16,
   parameter int CTL_BITS     = 8,
   parameter int CNT_BITS     = $clog2(NUM_ELEMENTS + 1)
) (
   input logic                     i_clk,
   input logic                     i_rst,
   adder_tree_term_packer_if.slave bus
);
   localparam int IDX_BITS = (NUM_ELEMENTS > 1) ? $clog2(NUM_ELEMENTS) : 1;
   localparam logic [IDX_BITS-1:0] LAST_IDX = IDX_BITS'(NUM_ELEMENTS - 1);

   logic [IDX_BITS-1:0]                  idx;
   logic [NUM_ELEMENTS-1:0][BIT_LEN-1:0] terms;
   logic [CNT_BITS-1:0]                  cnt;
   logic                                 val;
   logic                                 sop;
   logic                                 eop;
   logic                                 err;
   logic [CTL_BITS-1:0]                  ctl;
   logic                                 rdy;
   logic                                 accept;
   logic                                 drain;
   logic                                 complete;

   // Ready looks through the output register so a drain and a new term share one edge.
   always_comb begin
      rdy      = i_rst && (!val || bus.i_rdy);
      accept   = bus.i_val && rdy;
      drain    = val && bus.i_rdy;
      complete = (idx == LAST_IDX) || bus.i_eop;
   end

   // A drain zeroes the vector first; the accepted term then overrides its own slot.
   always_ff @(posedge i_clk) begin
      if (!i_rst) begin
         idx   <= '0;
         terms <= '0;
         cnt   <= '0;
         val   <= 1'b0;
         sop   <= 1'b0;
         eop   <= 1'b0;
         err   <= 1'b0;
         ctl   <= '0;
      end else begin
         if (drain) begin
            val   <= 1'b0;
            terms <= '0;
            cnt   <= '0;
            sop   <= 1'b0;
            eop   <= 1'b0;
         end
         if (accept) begin
            for (int i = 0; i < NUM_ELEMENTS; i++) begin
               if (idx == IDX_BITS'(i)) begin
                  terms[i] <= bus.i_dat;
               end
            end
            if (idx == '0) begin
               ctl <= bus.i_ctl;
               sop <= bus.i_sop;
            end else if (bus.i_sop) begin
               err <= 1'b1;
            end
            if (complete) begin
               val <= 1'b1;
               eop <= bus.i_eop;
               cnt <= CNT_BITS'(idx) + CNT_BITS'(1);
               idx <= '0;
            end else begin
               idx <= idx + IDX_BITS'(1);
            end
         end
      end
   end

   assign bus.o_rdy   = rdy;
   assign bus.o_terms = terms;
   assign bus.o_cnt   = cnt;
   assign bus.o_val   = val;
   assign bus.o_sop   = sop;
   assign bus.o_eop   = eop;
   assign bus.o_ctl   = ctl;
   assign bus.o_err   = err;
endmodule

// File: tb/tb_adder_tree_term_packer.sv
// Directed and randomized checks of adder_tree_term_packer with 4 x 16-bit terms.
// Vectors are compared as {val, terms[3..0], cnt, sop, eop, ctl}.
module tb_adder_tree_term_packer;
   localparam int N  = 4;
   localparam int BL = 16;
   localparam int CB = 8;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   n_checks = 0;
   int   n_fail   = 0;

   always #5 clk = ~clk;

   adder_tree_term_packer_if #(.NUM_ELEMENTS(N), .BIT_LEN(BL), .CTL_BITS(CB)) bus ();

   adder_tree_term_packer #(.NUM_ELEMENTS(N), .BIT_LEN(BL), .CTL_BITS(CB)) dut (
      .i_clk (clk),
      .i_rst (rst),
      .bus   (bus.slave)
   );

   task automatic idle_inputs();
      bus.i_val = 1'b0;
      bus.i_dat = '0;
      bus.i_sop = 1'b0;
      bus.i_eop = 1'b0;
      bus.i_ctl = '0;
   endtask

   task automatic drive(input logic [15:0] d, input logic s, input logic e, input logic [7:0] c);
      bus.i_val = 1'b1;
      bus.i_dat = d;
      bus.i_sop = s;
      bus.i_eop = e;
      bus.i_ctl = c;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst       = 1'b0;
      bus.i_rdy = 1'b1;
      drive(16'h1234, 1'b1, 1'b0, 8'hAB);
      for (int i = 0; i < 3; i++) begin
         step();
         n_checks++;
         if ({bus.o_val, bus.o_rdy, bus.o_err, bus.o_cnt} !== 6'b0) begin
            n_fail++;
            $display("[TB] FAIL reset_flags cyc%0d got val/rdy/err/cnt=%b want 000000", i,
                     {bus.o_val, bus.o_rdy, bus.o_err, bus.o_cnt});
         end
         n_checks++;
         if (bus.o_terms !== 64'h0) begin
            n_fail++;
            $display("[TB] FAIL reset_terms cyc%0d got %h want 0", i, bus.o_terms);
         end
      end
      idle_inputs();
      rst = 1'b1;
      #1;
      n_checks++;
      if (bus.o_rdy !== 1'b1) begin
         n_fail++;
         $display("[TB] FAIL reset_release_rdy got %b want 1", bus.o_rdy);
      end
   endtask

   task automatic test_full_packet();
      bus.i_rdy = 1'b1;
      for (int i = 1; i <= 8; i++) begin
         drive(16'(i), i == 1, i == 8, 8'h5A);
         step();
         if (i == 3) begin
            n_checks++;
            if (bus.o_val !== 1'b0) begin
               n_fail++;
               $display("[TB] FAIL full_early_val got %b want 0", bus.o_val);
            end
         end
         if (i == 4) begin
            n_checks++;
            if ({bus.o_val, bus.o_terms, bus.o_cnt, bus.o_sop, bus.o_eop, bus.o_ctl} !==
                {1'b1, 16'd4, 16'd3, 16'd2, 16'd1, 3'd4, 1'b1, 1'b0, 8'h5A}) begin
               n_fail++;
               $display("[TB] FAIL full_vec0 got %h want %h",
                        {bus.o_val, bus.o_terms, bus.o_cnt, bus.o_sop, bus.o_eop, bus.o_ctl},
                        {1'b1, 16'd4, 16'd3, 16'd2, 16'd1, 3'd4, 1'b1, 1'b0, 8'h5A});
            end
         end
         if (i == 8) begin
            n_checks++;
            if ({bus.o_val, bus.o_terms, bus.o_cnt, bus.o_sop, bus.o_eop, bus.o_ctl} !==
                {1'b1, 16'd8, 16'd7, 16'd6, 16'd5, 3'd4, 1'b0, 1'b1, 8'h5A}) begin
               n_fail++;
               $display("[TB] FAIL full_vec1 got %h want %h",
                        {bus.o_val, bus.o_terms, bus.o_cnt, bus.o_sop, bus.o_eop, bus.o_ctl},
                        {1'b1, 16'd8, 16'd7, 16'd6, 16'd5, 3'd4, 1'b0, 1'b1, 8'h5A});
            end
         end
      end
      idle_inputs();
      step();
      n_checks++;
      if (bus.o_val !== 1'b0) begin
         n_fail++;
         $display("[TB] FAIL full_drain_val got %b want 0", bus.o_val);
      end
   endtask

   task automatic test_short_packets();
      bus.i_rdy = 1'b1;
      for (int k = 0; k < 7; k++) begin
         drive((k < 6) ? 16'(10 + k) : 16'hFFFF, (k == 0) || (k == 6), (k == 5) || (k == 6),
               (k < 6) ? 8'h33 : 8'h77);
         step();
         if (k == 3) begin
            n_checks++;
            if ({bus.o_val, bus.o_terms, bus.o_cnt, bus.o_sop, bus.o_eop, bus.o_ctl} !==
                {1'b1, 16'd13, 16'd12, 16'd11, 16'd10, 3'd4, 1'b1, 1'b0, 8'h33}) begin
               n_fail++;
               $display("[TB] FAIL short_vec0 got %h want %h",
                        {bus.o_val, bus.o_terms, bus.o_cnt, bus.o_sop, bus.o_eop, bus.o_ctl},
                        {1'b1, 16'd13, 16'd12, 16'd11, 16'd10, 3'd4, 1'b1, 1'b0, 8'h33});
            end
         end
         if (k == 4) begin
            n_checks++;
            if (bus.o_val !== 1'b0) begin
               n_fail++;
               $display("[TB] FAIL short_mid_val got %b want 0", bus.o_val);
            end
         end
         if (k == 5) begin
            n_checks++;
            if ({bus.o_val, bus.o_terms, bus.o_cnt, bus.o_sop, bus.o_eop, bus.o_ctl} !==
                {1'b1, 16'd0, 16'd0, 16'd15, 16'd14, 3'd2, 1'b0, 1'b1, 8'h33}) begin
               n_fail++;
               $display("[TB] FAIL short_vec1 got %h want %h",
                        {bus.o_val, bus.o_terms, bus.o_cnt, bus.o_sop, bus.o_eop, bus.o_ctl},
                        {1'b1, 16'd0, 16'd0, 16'd15, 16'd14, 3'd2, 1'b0, 1'b1, 8'h33});
            end
         end
         if (k == 6) begin
            n_checks++;
            if ({bus.o_val, bus.o_terms, bus.o_cnt, bus.o_sop, bus.o_eop, bus.o_ctl} !==
                {1'b1, 16'd0, 16'd0, 16'd0, 16'hFFFF, 3'd1, 1'b1, 1'b1, 8'h77}) begin
               n_fail++;
               $display("[TB] FAIL short_vec2 got %h want %h",
                        {bus.o_val, bus.o_terms, bus.o_cnt, bus.o_sop, bus.o_eop, bus.o_ctl},
                        {1'b1, 16'd0, 16'd0, 16'd0, 16'hFFFF, 3'd1, 1'b1, 1'b1, 8'h77});
            end
         end
      end
      idle_inputs();
      step();
   endtask

   task automatic test_backpressure();
      bus.i_rdy = 1'b0;
      for (int i = 1; i <= 4; i++) begin
         drive(16'(i), i == 1, 1'b0, 8'h11);
         step();
      end
      drive(16'h0099, 1'b0, 1'b0, 8'hEE);
      for (int c = 0; c < 5; c++) begin
         n_checks++;
         if (bus.o_rdy !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL bp_rdy cyc%0d got %b want 0", c, bus.o_rdy);
         end
         n_checks++;
         if ({bus.o_val, bus.o_terms, bus.o_cnt, bus.o_sop, bus.o_eop, bus.o_ctl} !==
             {1'b1, 16'd4, 16'd3, 16'd2, 16'd1, 3'd4, 1'b1, 1'b0, 8'h11}) begin
            n_fail++;
            $display("[TB] FAIL bp_hold cyc%0d got %h want %h", c,
                     {bus.o_val, bus.o_terms, bus.o_cnt, bus.o_sop, bus.o_eop, bus.o_ctl},
                     {1'b1, 16'd4, 16'd3, 16'd2, 16'd1, 3'd4, 1'b1, 1'b0, 8'h11});
         end
         step();
      end
      bus.i_rdy = 1'b1;
      drive(16'd5, 1'b0, 1'b0, 8'h22);
      #1;
      n_checks++;
      if (bus.o_rdy !== 1'b1) begin
         n_fail++;
         $display("[TB] FAIL bp_release_rdy got %b want 1", bus.o_rdy);
      end
      @(posedge clk);
      #1;
      n_checks++;
      if ({bus.o_val, bus.o_terms, bus.o_cnt, bus.o_sop, bus.o_eop, bus.o_ctl} !==
          {1'b0, 16'd0, 16'd0, 16'd0, 16'd5, 3'd0, 1'b0, 1'b0, 8'h22}) begin
         n_fail++;
         $display("[TB] FAIL bp_slot0 got %h want %h",
                  {bus.o_val, bus.o_terms, bus.o_cnt, bus.o_sop, bus.o_eop, bus.o_ctl},
                  {1'b0, 16'd0, 16'd0, 16'd0, 16'd5, 3'd0, 1'b0, 1'b0, 8'h22});
      end
      for (int i = 6; i <= 8; i++) begin
         drive(16'(i), 1'b0, i == 8, 8'h22);
         step();
      end
      n_checks++;
      if ({bus.o_val, bus.o_terms, bus.o_cnt, bus.o_sop, bus.o_eop, bus.o_ctl} !==
          {1'b1, 16'd8, 16'd7, 16'd6, 16'd5, 3'd4, 1'b0, 1'b1, 8'h22}) begin
         n_fail++;
         $display("[TB] FAIL bp_next_vec got %h want %h",
                  {bus.o_val, bus.o_terms, bus.o_cnt, bus.o_sop, bus.o_eop, bus.o_ctl},
                  {1'b1, 16'd8, 16'd7, 16'd6, 16'd5, 3'd4, 1'b0, 1'b1, 8'h22});
      end
      idle_inputs();
      step();
   endtask

   task automatic test_framing_error();
      bus.i_rdy = 1'b1;
      for (int i = 1; i <= 8; i++) begin
         drive(16'(32 + i), (i == 1) || (i == 7), i == 8, 8'h44);
         step();
         if (i == 4) begin
            n_checks++;
            if ({bus.o_err, bus.o_val, bus.o_terms, bus.o_cnt, bus.o_sop, bus.o_eop, bus.o_ctl} !==
                {1'b0, 1'b1, 16'h24, 16'h23, 16'h22, 16'h21, 3'd4, 1'b1, 1'b0, 8'h44}) begin
               n_fail++;
               $display("[TB] FAIL frame_vec0 got %h want %h",
                        {bus.o_err, bus.o_val, bus.o_terms, bus.o_cnt, bus.o_sop, bus.o_eop, bus.o_ctl},
                        {1'b0, 1'b1, 16'h24, 16'h23, 16'h22, 16'h21, 3'd4, 1'b1, 1'b0, 8'h44});
            end
         end
         if (i == 7) begin
            n_checks++;
            if (bus.o_err !== 1'b1) begin
               n_fail++;
               $display("[TB] FAIL frame_err_set got %b want 1", bus.o_err);
            end
         end
         if (i == 8) begin
            n_checks++;
            if ({bus.o_val, bus.o_terms, bus.o_cnt, bus.o_sop, bus.o_eop, bus.o_ctl} !==
                {1'b1, 16'h28, 16'h27, 16'h26, 16'h25, 3'd4, 1'b0, 1'b1, 8'h44}) begin
               n_fail++;
               $display("[TB] FAIL frame_vec1 got %h want %h",
                        {bus.o_val, bus.o_terms, bus.o_cnt, bus.o_sop, bus.o_eop, bus.o_ctl},
                        {1'b1, 16'h28, 16'h27, 16'h26, 16'h25, 3'd4, 1'b0, 1'b1, 8'h44});
            end
         end
      end
      idle_inputs();
      repeat (3) step();
      n_checks++;
      if ({bus.o_err, bus.o_val} !== 2'b10) begin
         n_fail++;
         $display("[TB] FAIL frame_err_sticky got err/val=%b want 10", {bus.o_err, bus.o_val});
      end
      rst = 1'b0;
      step();
      n_checks++;
      if (bus.o_err !== 1'b0) begin
         n_fail++;
         $display("[TB] FAIL frame_err_reset got %b want 0", bus.o_err);
      end
      rst = 1'b1;
      step();
   endtask

   task automatic test_random_soak();
      logic [15:0] dq[$];
      logic        sq[$];
      logic        eq[$];
      logic [7:0]  cq[$];
      logic [77:0] expq[$];
      logic [15:0] pd[13];
      logic [7:0]  pc[13];
      logic [63:0] tv;
      int          len;
      int          cnt;
      int          rx;
      logic        acc;
      int          guard;
      int          cycles;

      for (int p = 0; p < 200; p++) begin
         len = $urandom_range(1, 13);
         for (int j = 0; j < len; j++) begin
            pd[j] = 16'($urandom);
            pc[j] = 8'($urandom);
            dq.push_back(pd[j]);
            sq.push_back(j == 0);
            eq.push_back(j == len - 1);
            cq.push_back(pc[j]);
         end
         for (int c = 0; c < len; c += N) begin
            cnt = (len - c < N) ? (len - c) : N;
            tv  = '0;
            for (int j = 0; j < cnt; j++) tv[16*j +: 16] = pd[c+j];
            expq.push_back({1'b1, tv, 3'(cnt), c == 0, c + cnt == len, pc[c]});
         end
      end

      rx = 0;
      fork
         begin
            for (int t = 0; t < dq.size(); t++) begin
               if ($urandom_range(0, 3) == 0) begin
                  idle_inputs();
                  step();
               end
               drive(dq[t], sq[t], eq[t], cq[t]);
               acc   = 1'b0;
               guard = 0;
               while (!acc && guard < 200) begin
                  @(negedge clk);
                  acc = bus.o_rdy;
                  step();
                  guard++;
               end
               if (!acc) begin
                  n_checks++;
                  n_fail++;
                  $display("[TB] FAIL soak_drive_timeout term %0d got no ready want ready", t);
                  break;
               end
            end
            idle_inputs();
         end
         begin
            cycles = 0;
            while (rx < expq.size() && cycles < 30000) begin
               bus.i_rdy = ($urandom_range(0, 3) != 0);
               @(negedge clk);
               if (bus.o_val && bus.i_rdy) begin
                  n_checks++;
                  if ({bus.o_val, bus.o_terms, bus.o_cnt, bus.o_sop, bus.o_eop, bus.o_ctl} !== expq[rx]) begin
                     n_fail++;
                     $display("[TB] FAIL soak_vec%0d got %h want %h", rx,
                              {bus.o_val, bus.o_terms, bus.o_cnt, bus.o_sop, bus.o_eop, bus.o_ctl}, expq[rx]);
                  end
                  rx++;
               end
               step();
               cycles++;
            end
         end
      join
      bus.i_rdy = 1'b1;
      n_checks++;
      if (rx !== expq.size()) begin
         n_fail++;
         $display("[TB] FAIL soak_count got %0d vectors want %0d", rx, expq.size());
      end
      n_checks++;
      if (bus.o_err !== 1'b0) begin
         n_fail++;
         $display("[TB] FAIL soak_err got %b want 0", bus.o_err);
      end
   endtask

   initial begin
      idle_inputs();
      bus.i_rdy = 1'b1;
      test_reset();
      test_full_packet();
      test_short_packets();
      test_backpressure();
      test_framing_error();
      test_random_soak();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/adder_tree_term_packer.md
# adder_tree_term_packer

Stream-to-vector packer that feeds the pipelined adder tree. It accepts one BIT_LEN term per handshake on a sop/eop-framed stream and groups consecutive terms into NUM_ELEMENTS-wide vectors. Any unused tail slots are zero-filled, and each completed vector is presented with its own val/rdy/sop/eop/ctl. It sits directly upstream of the adder tree, converting serial term producers (e.g. point/coefficient streamers) into the parallel term bus the tree consumes.

## Interface
- NUM_ELEMENTS, 4, terms per output vector; must be >= 1
- BIT_LEN, 16, width of one term
- CTL_BITS, 8, sideband control width
- CNT_BITS, $clog2(NUM_ELEMENTS+1), derived; do not override

- i_clk  in  1  sole clock, all logic rising-edge
- i_rst  in  1  reset, synchronous, active-low (0 = reset)
- i_dat  in  BIT_LEN  input term
- i_val  in  1  input term valid
- i_sop  in  1  first term of packet
- i_eop  in  1  last term of packet
- i_ctl  in  CTL_BITS  input sideband
- o_rdy  out  1  packer can accept a term this cycle
- o_terms  out  BIT_LEN x [NUM_ELEMENTS]  packed vector, slot 0 = earliest term
- o_cnt  out  CNT_BITS  number of real terms in o_terms (1..NUM_ELEMENTS)
- o_val  out  1  o_terms/o_cnt/o_sop/o_eop/o_ctl valid
- o_sop  out  1  vector holds packet's first term
- o_eop  out  1  vector holds packet's last term
- o_ctl  out  CTL_BITS  i_ctl of the vector's slot-0 term
- i_rdy  in  1  downstream (adder tree) ready
- o_err  out  1  sticky framing error flag

## Operation
- Input handshake: term accepted when i_val && o_rdy. Output handshake: vector consumed when o_val && i_rdy.
- o_rdy = i_rst && (!o_val || i_rdy). Combinational; a term may be accepted in the same cycle a vector drains.
- Internal slot index idx (0..NUM_ELEMENTS-1). An accepted term is written to o_terms[idx]. At idx 0, o_ctl <= i_ctl and o_sop <= i_sop.
- Completion: an accepted term completes the vector when idx == NUM_ELEMENTS-1 or i_eop=1. On completion: o_val <= 1, o_eop <= i_eop, o_cnt <= idx+1, idx <= 0. Otherwise idx <= idx+1.
- Unwritten slots of a completed vector read 0, so the adder tree sum is unaffected.
- Output handshake without a simultaneous accept: o_val <= 0, all o_terms <= 0, o_cnt <= 0, o_sop/o_eop <= 0.
- Output handshake with a simultaneous accept: the vector is cleared and the new term is written to slot 0 in the same edge. If NUM_ELEMENTS==1 or i_eop=1, o_val stays 1 with the new vector.
- While o_val=0, o_terms shows the partial vector; it is don't-care to downstream.
- Framing error: i_sop accepted at idx != 0 sets o_err <= 1. Packing continues unchanged, and that sop bit is dropped. o_err clears only on reset.
- Terms carry no arithmetic; widths pass through unchanged.

## Timing
- Reset (i_rst=0 at a clock edge) forces: o_val=0, o_sop=0, o_eop=0, o_ctl=0, o_cnt=0, o_terms all 0, o_err=0, idx=0. o_rdy=0 while i_rst=0; o_rdy=1 on the first cycle after release.
- Reset mid-vector discards the partial vector and any held output vector; no partial emission follows.
- Latency: o_val rises on the edge that accepts the completing term, i.e. visible in the next cycle.
- Throughput: 1 term/cycle sustained when i_rdy=1; full vectors issue back-to-back with no bubble.
- Backpressure: while o_val=1 && i_rdy=0, o_rdy=0 and all outputs hold stable. No term is lost or duplicated.
- NUM_ELEMENTS=1: every accepted term is a vector, with o_cnt=1 and o_sop/o_eop mirroring the input.

## Test plan
- Reset: i_rst=0 for 3 cycles with i_val=1, i_dat=0x1234 -> o_val=0, o_rdy=0, o_terms all 0, o_err=0. First cycle after release -> o_rdy=1.
- Full packet (NUM_ELEMENTS=4, BIT_LEN=16): terms 1..8, sop on 1, eop on 8, ctl 0x5A, i_rdy=1 -> [1,2,3,4] cnt=4 sop=1 eop=0, then [5,6,7,8] cnt=4 sop=0 eop=1, ctl=0x5A both. Each o_val appears the cycle after its 4th term.
- Short packets: terms 10..15 (sop@10, eop@15), then single term 0xFFFF (sop&eop) -> [10,11,12,13] cnt=4; [14,15,0,0] cnt=2 eop=1; [0xFFFF,0,0,0] cnt=1 sop=1 eop=1.
- Backpressure: i_rdy=0 for 5 cycles after vector [1,2,3,4] completes -> o_rdy=0 and outputs stable. Raise i_rdy with i_val=1, i_dat=5 in the same cycle -> vector drains, 5 lands in slot 0, no loss.
- Framing error: sop asserted on the 3rd term of a vector -> o_err=1 and stays 1. Vector still emitted with cnt=4 and o_sop from slot 0. Reset clears o_err.
- Random soak: 200 packets of length 1..13, random i_val/i_rdy gaps, compared against a reference model -> every vector's terms/cnt/sop/eop/ctl match, zero-padding correct, o_err=0.
